scaler_v: RTL and testbench

- Vertical video scaler: linear interpolation between two adjacent input lines.
- Step is programmable in unsigned 4.12 fixed point.
- Stores incoming lines in a ring of five line buffers (buf0..buf4).
- Regenerates output lines of v_scale_line_size pixels with its own hs/vs framing; sits in the scaler2 pipeline after horizontal processing.

---
 rtl/scaler_v.sv | 189 ++++++++++++++++++
 tb/tb_scaler_v.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_v.sv
// Vertical scaler: two-tap line interpolation over a five-line ring buffer.
// Define SCALER_V_NEAREST_EN to pick the nearest line instead of blending.
module scaler_v #(
   parameter int PIXEL_WIDTH   = 8,
   parameter int SPARSE_OUTPUT = 1,
   parameter int COE_WIDTH     = 8,
   parameter int LINE_SIZE_MAX = 2048
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            v_scale_step,
   input  logic [15:0]            v_scale_line_size,
   input  logic [PIXEL_WIDTH-1:0] di_i,
   input  logic                   de_i,
   input  logic                   hs_i,
   input  logic                   vs_i,
   output logic [PIXEL_WIDTH-1:0] do_o,
   output logic                   de_o,
   output logic                   hs_o,
   output logic                   vs_o
);

   localparam int PW = PIXEL_WIDTH;
   localparam int C  = COE_WIDTH;
   localparam int AW = $clog2(LINE_SIZE_MAX);
   localparam int XW = AW + 1;
   localparam logic [XW-1:0] XMAX = XW'(LINE_SIZE_MAX);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] EOL  = 2'd2;

   logic [PW-1:0] lbuf [5][LINE_SIZE_MAX];

   logic [XW-1:0] wr_x;
   logic [2:0]    wr_idx;
   logic [11:0]   lines_in;
   logic          wr_en;

   logic [22:0]   pos;
   logic [23:0]   pos_sum;
   logic [15:0]   step_r;
   logic [XW-1:0] size_r;
   logic [XW-1:0] size_n;
   logic [XW-1:0] rx;
   logic [1:0]    state;
   logic          phase;

   logic [10:0]   n;
   logic [C-1:0]  f;
   logic [2:0]    ra;
   logic [2:0]    rb;
   logic          ready;
   logic          rd_en;
   logic          last;

   logic          s1_v;
   logic          s1_hs;
   logic [C-1:0]  s1_f;
   logic [PW-1:0] s1_a;
   logic [PW-1:0] s1_b;
   logic          s2_v;
   logic          s2_hs;
   logic [PW-1:0] s2_pix;
   logic [PW-1:0] mix;

   assign wr_en   = de_i && (wr_x < XMAX);
   assign n       = pos[22:12];
   assign f       = pos[11:12-C];
   assign ra      = 3'(n % 11'd5);
   assign rb      = (ra == 3'd4) ? 3'd0 : ra + 3'd1;
   assign ready   = (12'(n) + 12'd2) <= lines_in;
   assign rd_en   = (state == RUN) && !phase;
   assign last    = rx == (size_r - XW'(1));
   assign pos_sum = {1'b0, pos} + {8'd0, step_r};

   // Out-of-range sizes are clamped so reads stay inside the line RAM.
   always_comb begin
      size_n = XMAX;
      if (v_scale_line_size == 16'd0)
         size_n = XW'(1);
      else if (v_scale_line_size < 16'(LINE_SIZE_MAX))
         size_n = v_scale_line_size[XW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_x     <= '0;
         wr_idx   <= 3'd0;
         lines_in <= '0;
      end else if (vs_i) begin
         wr_x     <= '0;
         wr_idx   <= 3'd0;
         lines_in <= '0;
      end else if (hs_i) begin
         wr_x     <= '0;
         wr_idx   <= (wr_idx == 3'd4) ? 3'd0 : wr_idx + 3'd1;
         lines_in <= (lines_in == '1) ? lines_in : lines_in + 12'd1;
      end else if (wr_en) begin
         wr_x <= wr_x + XW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         phase  <= 1'b0;
         rx     <= '0;
         pos    <= '0;
         step_r <= 16'd4096;
         size_r <= XW'(1);
      end else if (vs_i) begin
         state  <= IDLE;
         phase  <= 1'b0;
         rx     <= '0;
         pos    <= '0;
         step_r <= v_scale_step;
         size_r <= size_n;
      end else begin
         unique case (state)
            IDLE: begin
               if (ready) begin
                  state <= RUN;
                  rx    <= '0;
                  phase <= 1'b0;
               end
            end
            RUN: begin
               phase <= (SPARSE_OUTPUT != 0) ? ~phase : 1'b0;
               if (rd_en) begin
                  rx <= rx + XW'(1);
                  if (last)
                     state <= EOL;
               end
            end
            EOL: begin
               pos   <= pos_sum[23] ? '1 : pos_sum[22:0];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCALER_V_NEAREST_EN
   localparam logic [C-1:0] HALF = C'(2**(C-1));
   assign mix = (s1_f < HALF) ? s1_a : s1_b;
`else
   localparam int SW = PW + C + 1;
   logic [C:0] wa;
   assign wa  = (C+1)'(2**C) - (C+1)'(s1_f);
   assign mix = PW'((SW'(s1_a) * SW'(wa) + SW'(s1_b) * SW'(s1_f)
                + SW'(2**(C-1))) >> C);
`endif

   // Line RAM and datapath registers carry no reset; only valids do.
   always_ff @(posedge clk) begin
      if (wr_en)
         lbuf[wr_idx][wr_x[AW-1:0]] <= di_i;
      s1_a   <= lbuf[ra][rx[AW-1:0]];
      s1_b   <= lbuf[rb][rx[AW-1:0]];
      s1_f   <= f;
      s2_pix <= mix;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v  <= 1'b0;
         s1_hs <= 1'b0;
         s2_v  <= 1'b0;
         s2_hs <= 1'b0;
         de_o  <= 1'b0;
         hs_o  <= 1'b0;
         vs_o  <= 1'b0;
         do_o  <= '0;
      end else begin
         vs_o  <= vs_i;
         s1_v  <= rd_en && !vs_i;
         s1_hs <= (state == EOL) && !vs_i;
         s2_v  <= s1_v && !vs_i;
         s2_hs <= s1_hs && !vs_i;
         de_o  <= s2_v && !vs_i;
         hs_o  <= s2_hs && !vs_i;
         if (s2_v)
            do_o <= s2_pix;
      end
   end

endmodule

// File: tb/tb_scaler_v.sv
// Scoreboard bench for scaler_v: sparse instance plus a dense-output one.
module tb_scaler_v;

   localparam int K_PIX = 0;
   localparam int K_HS  = 1;
   localparam int K_VS  = 2;

   typedef struct {
      int k;
      int v;
      bit care;
      bit ab;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] step = 16'd4096;
   logic [15:0] lsize = 16'd1100;
   logic [7:0]  di = '0;
   logic [7:0]  di2 = '0;
   logic        de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic        de2 = 1'b0, hs2 = 1'b0, vs2 = 1'b0;
   logic [7:0]  dout, dout2;
   logic        deo, hso, vso, deo2, hso2, vso2;

   item_t q[$];
   item_t q2[$];
   int n_vec = 0, n_err = 0;
   int cyc = 0, vs_cyc = -10;
   int de_cnt = 0, vs2_cnt = 0;
   int last_de = 0, last2 = 0;
   bit in_line = 0, in2 = 0;

`ifdef SCALER_V_NEAREST_EN
   int ups[6] = '{0, 16, 16, 32, 32, 48};
   int dns[4] = '{10, 10, 21, 21};
`else
   int ups[6] = '{0, 8, 16, 24, 32, 40};
   int dns[4] = '{10, 13, 16, 18};
`endif

   always #5 clk = ~clk;

   scaler_v dut (
      .clk(clk), .rst(rst),
      .v_scale_step(step), .v_scale_line_size(lsize),
      .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
      .do_o(dout), .de_o(deo), .hs_o(hso), .vs_o(vso)
   );

   scaler_v #(.SPARSE_OUTPUT(0)) dut2 (
      .clk(clk), .rst(rst),
      .v_scale_step(step), .v_scale_line_size(lsize),
      .di_i(di2), .de_i(de2), .hs_i(hs2), .vs_i(vs2),
      .do_o(dout2), .de_o(deo2), .hs_o(hso2), .vs_o(vso2)
   );

   always @(posedge clk) begin
      cyc++;
      if (vs) vs_cyc = cyc;
   end

   always @(negedge clk) begin : mon1
      item_t it;
      if (!rst) begin
         if (vso) begin
            n_vec++;
            if (deo || hso || cyc != vs_cyc) begin
               n_err++;
               $display("FAIL vs_o: de_o=%0d hs_o=%0d cycle %0d, required 0 0 cycle %0d",
                        deo, hso, cyc, vs_cyc);
            end
            while (q.size() > 0 && q[0].ab && q[0].k != K_VS)
               it = q.pop_front();
            n_vec++;
            if (q.size() == 0 || q[0].k != K_VS) begin
               n_err++;
               $display("FAIL vs_order: got vs_o, required kind %0d first",
                        q.size() == 0 ? -1 : q[0].k);
            end else begin
               it = q.pop_front();
            end
            in_line = 0;
         end else if (deo) begin
            n_vec++;
            if (q.size() == 0 || q[0].k != K_PIX) begin
               n_err++;
               $display("FAIL de_o: got pixel %0d at cycle %0d, required no pixel",
                        dout, cyc);
            end else begin
               it = q.pop_front();
               if (it.care && dout != 8'(it.v)) begin
                  n_err++;
                  $display("FAIL pixel: got %0d, required %0d", dout, it.v);
               end else if (in_line && cyc - last_de != 2) begin
                  n_err++;
                  $display("FAIL de_gap: got %0d clks, required 2", cyc - last_de);
               end
            end
            in_line = 1;
            last_de = cyc;
            de_cnt++;
         end else if (hso) begin
            n_vec++;
            if (q.size() == 0 || q[0].k != K_HS) begin
               n_err++;
               $display("FAIL hs_o: got hs_o at cycle %0d, required none", cyc);
            end else begin
               it = q.pop_front();
               if (cyc != last_de + 1) begin
                  n_err++;
                  $display("FAIL hs_gap: got %0d clks, required 1", cyc - last_de);
               end
            end
            in_line = 0;
         end
      end
   end

   always @(negedge clk) begin : mon2
      item_t it2;
      if (!rst) begin
         if (vso2) vs2_cnt++;
         if (deo2) begin
            n_vec++;
            if (q2.size() == 0 || q2[0].k != K_PIX) begin
               n_err++;
               $display("FAIL dense_de: got pixel %0d, required none", dout2);
            end else begin
               it2 = q2.pop_front();
               if (dout2 != 8'(it2.v)) begin
                  n_err++;
                  $display("FAIL dense_pixel: got %0d, required %0d", dout2, it2.v);
               end else if (in2 && cyc - last2 != 1) begin
                  n_err++;
                  $display("FAIL dense_gap: got %0d clks, required 1", cyc - last2);
               end
            end
            in2 = 1;
            last2 = cyc;
         end else if (hso2) begin
            n_vec++;
            if (q2.size() == 0 || q2[0].k != K_HS) begin
               n_err++;
               $display("FAIL dense_hs: got hs_o, required none");
            end else begin
               it2 = q2.pop_front();
               if (cyc != last2 + 1) begin
                  n_err++;
                  $display("FAIL dense_hs_gap: got %0d clks, required 1", cyc - last2);
               end
            end
            in2 = 0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic e, input logic [7:0] d,
                        input logic h, input logic v);
      if (sel) begin
         de2 = e; di2 = d; hs2 = h; vs2 = v;
      end else begin
         de = e; di = d; hs = h; vs = v;
      end
   endtask

   task automatic send_line(input bit sel, input int n, input int base,
                            input int inc, input int per);
      for (int x = 0; x < n; x++) begin
         @(posedge clk); #1;
         drive(sel, 1'b1, 8'(base + inc * x), 1'b0, 1'b0);
         for (int g = 1; g < per; g++) begin
            @(posedge clk); #1;
            drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
         end
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, 8'd0, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic push_line(input bit sel, input int base, input int inc,
                            input int size, input int care_n, input bit ab);
      item_t it;
      for (int x = 0; x < size; x++) begin
         it.k = K_PIX;
         it.v = (base + inc * x) & 255;
         it.care = (x < care_n);
         it.ab = ab;
         if (sel) q2.push_back(it);
         else q.push_back(it);
      end
      it.k = K_HS;
      it.v = 0;
      it.care = 1'b1;
      it.ab = ab;
      if (sel) q2.push_back(it);
      else q.push_back(it);
   endtask

   task automatic end_frame(input bit sel, input int st, input int sz);
      item_t it;
      @(posedge clk); #1;
      step = 16'(st);
      lsize = 16'(sz);
      drive(sel, 1'b0, 8'd0, 1'b1, 1'b1);
      if (!sel) begin
         it.k = K_VS; it.v = 0; it.care = 1'b1; it.ab = 1'b0;
         q.push_back(it);
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic wait_drain(input bit sel, input int maxc);
      int c = 0;
      while ((sel ? q2.size() : q.size()) > 0 && c < maxc) begin
         @(posedge clk);
         c++;
      end
      chk(sel ? "drain_dense" : "drain", sel ? q2.size() : q.size(), 0);
      repeat (4) @(posedge clk);
   endtask

   initial begin : stim
      int base;
      int snap;
      int c;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int x = 0; x < 10; x++) begin
         @(posedge clk); #1;
         drive(1'b0, 1'b1, 8'(x + 1), 1'b0, 1'b0);
      end
      rst = 1'b1;
      #2;
      chk("rst_do", int'(dout), 0);
      chk("rst_de", int'(deo), 0);
      chk("rst_hs", int'(hso), 0);
      chk("rst_vs", int'(vso), 0);
      drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      @(posedge clk); #1 rst = 1'b0;

      end_frame(1'b0, 4096, 1100);
      wait_drain(1'b0, 20);

      send_line(1'b0, 756, 0, 1, 6);
      repeat (20) @(posedge clk);
      chk("no_early_output", de_cnt, 0);
      send_line(1'b0, 756, 0, 1, 6);
      push_line(1'b0, 0, 1, 1100, 756, 1'b0);
      send_line(1'b0, 756, 0, 1, 6);
      push_line(1'b0, 0, 1, 1100, 756, 1'b0);
      wait_drain(1'b0, 6000);
      end_frame(1'b0, 2048, 20);
      wait_drain(1'b0, 20);

      for (int y = 0; y < 4; y++) begin
         send_line(1'b0, 20, 16 * y, 0, 1);
         if (y >= 1) begin
            push_line(1'b0, ups[2*y-2], 0, 20, 20, 1'b0);
            push_line(1'b0, ups[2*y-1], 0, 20, 20, 1'b0);
            wait_drain(1'b0, 400);
         end
      end
      end_frame(1'b0, 8192, 20);
      wait_drain(1'b0, 20);

      for (int y = 0; y < 5; y++) begin
         send_line(1'b0, 20, 16 * y, 0, 1);
         if (y == 1) push_line(1'b0, 0, 0, 20, 20, 1'b0);
         if (y == 3) push_line(1'b0, 32, 0, 20, 20, 1'b0);
         wait_drain(1'b0, 400);
      end
      end_frame(1'b0, 4096, 20);
      wait_drain(1'b0, 20);

      send_line(1'b0, 20, 5, 0, 1);
      send_line(1'b0, 20, 9, 0, 1);
      push_line(1'b0, 5, 0, 20, 20, 1'b1);
      base = de_cnt;
      c = 0;
      while (de_cnt < base + 3 && c < 500) begin
         @(posedge clk);
         c++;
      end
      chk("abort_line_started", int'(de_cnt >= base + 3), 1);
      end_frame(1'b0, 4096, 20);
      snap = de_cnt;
      repeat (30) @(posedge clk);
      chk("abort_no_more_de", de_cnt, snap);
      wait_drain(1'b0, 20);

      send_line(1'b0, 20, 100, 0, 1);
      send_line(1'b0, 20, 200, 0, 1);
      push_line(1'b0, 100, 0, 20, 20, 1'b0);
      wait_drain(1'b0, 400);
      end_frame(1'b0, 4096, 20);
      wait_drain(1'b0, 20);

      end_frame(1'b1, 1024, 16);
      send_line(1'b1, 16, 10, 1, 1);
      send_line(1'b1, 16, 21, 1, 1);
      for (int k = 0; k < 4; k++)
         push_line(1'b1, dns[k], 1, 16, 16, 1'b0);
      wait_drain(1'b1, 400);

      chk("final_queue", q.size(), 0);
      chk("final_queue_dense", q2.size(), 0);
      chk("dense_vs_count", vs2_cnt, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
